// File: rtl/ram_256x32.sv
// rtl/ram_256x32.sv - single-port synchronous RAM, registered read, optional RAM_CLEAR_EN post-reset clear sweep
module ram_256x32 #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          busy
);

  logic [DW-1:0] mem [2**AW];

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic          access_ok;

`ifdef RAM_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (cnt == {AW{1'b1}}) state <= IDLE;
          else                   cnt   <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == CLEAR);
  assign access_ok = !busy;

  // The sweep owns the write port while busy; user accesses are ignored.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = din;
    if (!rst) begin
      if (busy) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else if (cen && wen) begin
        mem_we = 1'b1;
      end
    end
  end
`else
  assign busy      = 1'b0;
  assign access_ok = 1'b1;

  always_comb begin
    mem_we = !rst && cen && wen;
    mem_wa = addr;
    mem_wd = din;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (rst || !access_ok || !cen || wen) dout <= '0;
    else                                  dout <= mem[addr];
  end

endmodule

// File: tb/tb_ram_256x32.sv
// tb/tb_ram_256x32.sv - self-checking bench for ram_256x32 against an array reference model
module tb_ram_256x32;

  logic        clk = 1'b0;
  logic        rst, cen, wen;
  logic [7:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [256];
  bit          known [256];

  always #5 clk = ~clk;

  ram_256x32 #(.AW(8), .DW(32)) dut (
    .clk(clk), .rst(rst), .cen(cen), .wen(wen),
    .addr(addr), .din(din), .dout(dout), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the model decides what dout must be after the edge.
  task automatic cyc(input string tag, input logic r, input logic c, input logic w,
                     input logic [7:0] a, input logic [31:0] d);
    logic [31:0] exp;
    bit          chk;
    @(negedge clk);
    rst = r; cen = c; wen = w; addr = a; din = d;
    exp = '0;
    chk = 1'b1;
    if (r) begin
`ifdef RAM_CLEAR_EN
      for (int i = 0; i < 256; i++) begin
        model[i] = '0;
        known[i] = 1'b1;
      end
`endif
    end else if (c && w) begin
      model[a] = d;
      known[a] = 1'b1;
    end else if (c) begin
      exp = model[a];
      chk = known[a];
    end
    @(posedge clk);
    #1;
    if (chk) check_val(tag, dout, exp);
`ifdef RAM_CLEAR_EN
    check_val({tag, "_busy"}, {31'd0, busy}, {31'd0, r});
`else
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
`endif
  endtask

  task automatic wait_sweep();
`ifdef RAM_CLEAR_EN
    int n = 0;
    @(negedge clk);
    rst = 1'b0; cen = 1'b1; wen = 1'b1; addr = 8'h11; din = 32'hBAD0BAD0;
    while (busy === 1'b1 && n < 1000) begin
      if (dout !== 32'd0) check_val("sweep_dout", dout, 32'd0);
      n++;
      @(posedge clk);
      #1;
    end
    check_val("sweep_len", n, 256);
`endif
  endtask

  initial begin
    rst = 1'b1; cen = 1'b1; wen = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    cyc("rst0", 1, 1, 0, 8'h00, 32'h0);
    cyc("rst1", 1, 1, 0, 8'h00, 32'h0);
    wait_sweep();

    cyc("wr11", 0, 1, 1, 8'h11, 32'h50);
    cyc("wr12", 0, 1, 1, 8'h12, 32'h60);
    cyc("wr13", 0, 1, 1, 8'h13, 32'h70);
    cyc("wr14", 0, 1, 1, 8'h14, 32'h80);
    check_val("const_rd11_ref", model[8'h11], 32'h50);

    cyc("rd11", 0, 1, 0, 8'h11, 32'h0);
    cyc("rd12", 0, 1, 0, 8'h12, 32'h0);
    cyc("rd13", 0, 1, 0, 8'h13, 32'h0);
    cyc("rd14", 0, 1, 0, 8'h14, 32'h0);
    cyc("rd15_unwritten", 0, 1, 0, 8'h15, 32'h0);

    cyc("idle_wen", 0, 0, 1, 8'h11, 32'hDEAD);
    cyc("rd11_after_idle", 0, 1, 0, 8'h11, 32'h0);
    cyc("wr11_ones", 0, 1, 1, 8'h11, 32'hFFFFFFFF);
    cyc("rd11_ones", 0, 1, 0, 8'h11, 32'h0);

    cyc("wr00", 0, 1, 1, 8'h00, 32'h1);
    cyc("wrff", 0, 1, 1, 8'hFF, 32'hA5A5A5A5);
    cyc("rd00", 0, 1, 0, 8'h00, 32'h0);
    cyc("rdff", 0, 1, 0, 8'hFF, 32'h0);

    for (int k = 0; k < 300; k++) begin
      logic        c, w;
      logic [7:0]  a;
      logic [31:0] d;
      c = ($urandom_range(0, 9) != 0);
      w = $urandom_range(0, 1);
      a = 8'h20 + 8'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) a = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      d = $urandom;
      cyc("rand", 0, c, w, a, d);
    end

    cyc("wr30", 0, 1, 1, 8'h30, 32'h12345678);
    cyc("rst_wr30", 1, 1, 1, 8'h30, 32'hCAFEF00D);
    wait_sweep();
    cyc("rd30_after_rst", 0, 1, 0, 8'h30, 32'h0);
    cyc("rdff_final", 0, 1, 0, 8'hFF, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
